// File: rtl/flash_burst_sequencer.sv
// flash_burst_sequencer: turns burst read/program and erase requests into single-byte
// commands for a start/ready flash controller, with a per-command timeout.
module flash_burst_sequencer #(
   parameter int TIMEOUT = 8388608,
   parameter int LEN_W   = 16
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic [1:0]       iOP,
   input  logic [21:0]      iADDR,
   input  logic [LEN_W-1:0] iLEN,
   input  logic             iGo,
   output logic             oBusy,
   output logic             oDone,
   output logic             oErr,
   input  logic [7:0]       iWR_DATA,
   input  logic             iWR_VALID,
   output logic             oWR_READY,
   output logic [7:0]       oRD_DATA,
   output logic             oRD_VALID,
   input  logic             iRD_READY,
   output logic [2:0]       oFL_CMD,
   output logic [21:0]      oFL_ADDR,
   output logic [7:0]       oFL_DATA,
   output logic             oFL_START,
   input  logic             iFL_READY,
   input  logic [7:0]       iFL_RDATA
);
   localparam logic [2:0] CMD_READ = 3'd0, CMD_WRITE = 3'd1, CMD_SEC_ERA = 3'd3, CMD_CHP_ERA = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_GET_WR, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_PUSH_RD, S_NEXT, S_FINISH
   } state_t;

   state_t           r_state, w_next;
   logic [1:0]       r_op;
   logic [LEN_W-1:0] r_rem;
   logic [22:0]      r_tmo;
   logic [2:0]       r_cmd;
   logic [21:0]      r_addr;
   logic [7:0]       r_data, r_rd_data;
   logic             r_start, r_rd_valid, r_err;
   logic             w_wait, w_tmo;

   assign w_wait    = r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE;
   assign w_tmo     = w_wait && r_tmo == 23'(TIMEOUT - 1);
   assign oBusy     = r_state != S_IDLE;
   assign oDone     = r_state == S_FINISH;
   assign oWR_READY = r_state == S_GET_WR;
   assign oErr      = r_err;
   assign oRD_DATA  = r_rd_data;
   assign oRD_VALID = r_rd_valid;
   assign oFL_CMD   = r_cmd;
   assign oFL_ADDR  = r_addr;
   assign oFL_DATA  = r_data;
   assign oFL_START = r_start;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (iGo) w_next = (!iOP[1] && iLEN == '0) ? S_FINISH : (iOP == 2'd1 ? S_GET_WR : S_ISSUE);
         S_GET_WR:    if (iWR_VALID) w_next = S_ISSUE;
         S_ISSUE:     w_next = S_WAIT_BUSY;
         S_WAIT_BUSY: w_next = w_tmo ? S_FINISH : (iFL_READY ? S_WAIT_BUSY : S_WAIT_DONE);
         S_WAIT_DONE: w_next = w_tmo ? S_FINISH : (!iFL_READY ? S_WAIT_DONE : (r_op == 2'd0 ? S_PUSH_RD : S_NEXT));
         S_PUSH_RD:   if (iRD_READY) w_next = S_NEXT;
         S_NEXT:      w_next = (r_op[1] || r_rem == LEN_W'(1)) ? S_FINISH : (r_op == 2'd0 ? S_ISSUE : S_GET_WR);
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_rem      <= '0;
         r_tmo      <= '0;
         r_cmd      <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_rd_data  <= '0;
         r_start    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_rd_valid <= w_next == S_PUSH_RD;
         r_tmo      <= r_state == S_ISSUE ? '0 : r_tmo + 23'd1;
         if (r_state == S_ISSUE)
            r_start <= 1'b1;
         else if (r_state == S_WAIT_BUSY && (!iFL_READY || w_tmo))
            r_start <= 1'b0;
         if (r_state == S_IDLE && iGo) begin
            r_op   <= iOP;
            r_rem  <= iLEN;
            r_addr <= iOP == 2'd2 ? '0 : iADDR;
            r_cmd  <= iOP == 2'd0 ? CMD_READ : iOP == 2'd2 ? CMD_CHP_ERA : iOP == 2'd3 ? CMD_SEC_ERA : r_cmd;
            r_err  <= 1'b0;
         end
         if (r_state == S_GET_WR && iWR_VALID) begin
            r_data <= iWR_DATA;
            r_cmd  <= CMD_WRITE;
         end
         // capture read data on the same edge that sees the controller finish
         if (r_state == S_WAIT_DONE && w_next == S_PUSH_RD)
            r_rd_data <= iFL_RDATA;
         if (r_state == S_NEXT && !r_op[1]) begin
            r_addr <= r_addr + 22'd1;
            r_rem  <= r_rem - LEN_W'(1);
         end
         if (w_tmo)
            r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_flash_burst_sequencer.sv
// tb_flash_burst_sequencer: randomized and directed checks of the burst sequencer
// against a flash controller model and an arithmetic reference of expected commands.
module tb_flash_burst_sequencer;
   typedef struct packed {logic [2:0] c; logic [21:0] a; logic [7:0] d;} cmd_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic [1:0]  op = '0;
   logic [21:0] addr = '0;
   logic [15:0] len = '0;
   logic        go = 1'b0, wr_valid = 1'b0, rd_ready = 1'b1;
   logic [7:0]  wr_data = '0;
   logic        fl_ready, busy, done, err, wr_ready, rd_valid, fl_start;
   logic [7:0]  fl_rdata, rd_data, fl_data;
   logic [2:0]  fl_cmd;
   logic [21:0] fl_addr;

   int   errors = 0, checks = 0;
   int   done_cnt = 0, getwr_start = 0, stab_err = 0;
   bit   hang = 0;
   cmd_t cmd_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] wbytes[$];

   always #5 clk = ~clk;

   flash_burst_sequencer #(.TIMEOUT(100), .LEN_W(16)) dut (
      .iCLK(clk), .iRST(rst), .iOP(op), .iADDR(addr), .iLEN(len), .iGo(go),
      .oBusy(busy), .oDone(done), .oErr(err),
      .iWR_DATA(wr_data), .iWR_VALID(wr_valid), .oWR_READY(wr_ready),
      .oRD_DATA(rd_data), .oRD_VALID(rd_valid), .iRD_READY(rd_ready),
      .oFL_CMD(fl_cmd), .oFL_ADDR(fl_addr), .oFL_DATA(fl_data), .oFL_START(fl_start),
      .iFL_READY(fl_ready), .iFL_RDATA(fl_rdata)
   );

   function automatic logic [7:0] rd_ref(input logic [21:0] a);
      return (a[7:0] + 8'h91) ^ a[15:8];
   endfunction

   function automatic int drift(input cmd_t c);
      return (busy && {fl_cmd, fl_addr, fl_data} !== c) ? 1 : 0;
   endfunction

   // flash controller model: reacts to start rising edges, drops ready within 2 cycles
   initial begin
      cmd_t cur;
      logic last;
      last = 1'b0;
      fl_ready = 1'b1;
      fl_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (fl_start && !last) begin
            cur = '{fl_cmd, fl_addr, fl_data};
            cmd_q.push_back(cur);
            if ($urandom_range(0, 1) == 1) begin
               @(posedge clk); #1;
               stab_err += drift(cur);
            end
            fl_ready = 1'b0;
            while (hang) begin
               @(posedge clk); #1;
               stab_err += drift(cur);
            end
            repeat ($urandom_range(1, 6)) begin
               fl_rdata = 8'($urandom);
               @(posedge clk); #1;
               stab_err += drift(cur);
            end
            fl_rdata = rd_ref(cur.a);
            fl_ready = 1'b1;
         end
         last = fl_start;
      end
   end

   initial forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
      if (fl_start && wr_ready) getwr_start++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         tick();
         ok = !busy;
      end
   endtask

   task automatic do_op(input logic [1:0] o, input logic [21:0] a, input logic [15:0] l, input int bp, output bit ok);
      int wi;
      cmd_q.delete();
      rd_q.delete();
      done_cnt = 0;
      getwr_start = 0;
      op = o; addr = a; len = l; go = 1'b1;
      tick();
      go = 1'b0; op = 2'($urandom); addr = 22'($urandom); len = 16'($urandom);
      wi = 0;
      ok = 0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         wr_valid = o == 2'd1 && wi < wbytes.size() && $urandom_range(0, 2) != 0;
         wr_data = wr_valid ? wbytes[wi] : 8'($urandom);
         rd_ready = bp == 0 || $urandom_range(0, bp) == 0;
         go = $urandom_range(0, 7) == 0;
         @(negedge clk);
         if (wr_valid && wr_ready) wi++;
         ok = done;
         tick();
      end
      go = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({busy, done, err, wr_ready, rd_valid, fl_start} !== 6'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 000000", {busy, done, err, wr_ready, rd_valid, fl_start});
      end
      checks++;
      if ({fl_cmd, fl_addr, fl_data} !== 33'b0) begin
         errors++; $display("FAIL reset_flash_bus: got %h expected 0", {fl_cmd, fl_addr, fl_data});
      end
      checks++;
      if (rd_data !== 8'h00) begin
         errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read_basic();
      bit ok;
      logic [7:0] exp [3];
      exp = '{8'hA1, 8'hA2, 8'hA3};
      do_op(2'd0, 22'h000010, 16'd3, 0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL read_done_timeout: got no oDone expected oDone"); end
      checks++;
      if (cmd_q.size() != 3) begin errors++; $display("FAIL read_cmd_count: got %0d expected 3", cmd_q.size()); end
      for (int i = 0; i < 3 && i < cmd_q.size(); i++) begin
         checks++;
         if ({cmd_q[i].c, cmd_q[i].a} !== {3'd0, 22'(22'h10 + i)}) begin
            errors++; $display("FAIL read_cmd[%0d]: got %h/%h expected 0/%h", i, cmd_q[i].c, cmd_q[i].a, 22'h10 + i);
         end
      end
      checks++;
      if (rd_q.size() != 3) begin errors++; $display("FAIL read_byte_count: got %0d expected 3", rd_q.size()); end
      for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
         checks++;
         if (rd_q[i] !== exp[i]) begin errors++; $display("FAIL read_byte[%0d]: got %h expected %h", i, rd_q[i], exp[i]); end
      end
      checks++;
      if (done_cnt != 1 || err !== 1'b0) begin
         errors++; $display("FAIL read_done_err: got done=%0d err=%b expected done=1 err=0", done_cnt, err);
      end
   endtask

   task automatic test_program();
      bit ok;
      logic [21:0] ea;
      wbytes = '{8'h11, 8'h22, 8'h33};
      do_op(2'd1, 22'h3FFFFE, 16'd3, 0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL prog_done_timeout: got no oDone expected oDone"); end
      checks++;
      if (cmd_q.size() != 3) begin errors++; $display("FAIL prog_cmd_count: got %0d expected 3", cmd_q.size()); end
      for (int i = 0; i < 3 && i < cmd_q.size(); i++) begin
         ea = 22'(22'h3FFFFE + i);
         checks++;
         if (cmd_q[i] !== {3'd1, ea, wbytes[i]}) begin
            errors++; $display("FAIL prog_cmd[%0d]: got %h expected %h", i, cmd_q[i], {3'd1, ea, wbytes[i]});
         end
      end
      checks++;
      if (getwr_start != 0 || done_cnt != 1) begin
         errors++; $display("FAIL prog_start_done: got start_in_getwr=%0d done=%0d expected 0 and 1", getwr_start, done_cnt);
      end
   endtask

   task automatic test_latency();
      bit ok;
      rd_ready = 1'b1;
      cmd_q.delete();
      op = 2'd0; addr = 22'h200; len = 16'd1; go = 1'b1;
      tick();
      go = 1'b0;
      checks++;
      if (fl_start !== 1'b0) begin errors++; $display("FAIL lat_read_early: got %b expected 0", fl_start); end
      tick();
      checks++;
      if (fl_start !== 1'b1) begin errors++; $display("FAIL lat_read: got %b expected 1", fl_start); end
      wait_idle(ok);
      op = 2'd1; addr = 22'h300; len = 16'd1; wr_valid = 1'b0; go = 1'b1;
      tick();
      go = 1'b0;
      repeat (5) tick();
      checks++;
      if (fl_start !== 1'b0 || wr_ready !== 1'b1) begin
         errors++; $display("FAIL lat_wr_stall: got start=%b ready=%b expected 0 1", fl_start, wr_ready);
      end
      wr_valid = 1'b1; wr_data = 8'h5C;
      tick();
      wr_valid = 1'b0;
      checks++;
      if (fl_start !== 1'b0) begin errors++; $display("FAIL lat_wr_early: got %b expected 0", fl_start); end
      tick();
      checks++;
      if (fl_start !== 1'b1) begin errors++; $display("FAIL lat_wr: got %b expected 1", fl_start); end
      wait_idle(ok);
      checks++;
      if (!ok || cmd_q.size() != 2 || cmd_q[1] !== {3'd1, 22'h300, 8'h5C}) begin
         errors++; $display("FAIL lat_wr_cmd: got n=%0d last=%h expected 2 and %h", cmd_q.size(), cmd_q[cmd_q.size()-1], {3'd1, 22'h300, 8'h5C});
      end
   endtask

   task automatic test_zero_len();
      for (int o = 0; o < 2; o++) begin
         cmd_q.delete();
         done_cnt = 0;
         op = 2'(o); len = 16'd0; addr = 22'($urandom); go = 1'b1;
         tick();
         go = 1'b0;
         repeat (2) tick();
         checks++;
         if (done_cnt != 1 || cmd_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_len_op%0d: got done=%0d cmds=%0d busy=%b expected 1 0 0", o, done_cnt, cmd_q.size(), busy);
         end
      end
   endtask

   task automatic test_erase();
      bit ok;
      do_op(2'd2, 22'h2ABCDE, 16'd9, 0, ok);
      checks++;
      if (!ok || cmd_q.size() != 1 || {cmd_q[0].c, cmd_q[0].a} !== {3'd4, 22'h0}) begin
         errors++; $display("FAIL chip_erase: got n=%0d cmd=%h expected 1 and %h", cmd_q.size(), {cmd_q[0].c, cmd_q[0].a}, {3'd4, 22'h0});
      end
      do_op(2'd3, 22'h000123, 16'd0, 0, ok);
      checks++;
      if (!ok || cmd_q.size() != 1 || {cmd_q[0].c, cmd_q[0].a} !== {3'd3, 22'h123}) begin
         errors++; $display("FAIL sector_erase: got n=%0d cmd=%h expected 1 and %h", cmd_q.size(), {cmd_q[0].c, cmd_q[0].a}, {3'd3, 22'h123});
      end
   endtask

   task automatic test_backpressure();
      bit ok, found;
      int hold;
      logic [7:0] d;
      cmd_q.delete();
      rd_q.delete();
      rd_ready = 1'b0;
      op = 2'd0; addr = 22'h20; len = 16'd2; go = 1'b1;
      tick();
      go = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         found = rd_valid;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL bp_valid_timeout: got no oRD_VALID expected oRD_VALID"); end
      d = rd_data;
      checks++;
      if (d !== rd_ref(22'h20)) begin errors++; $display("FAIL bp_first_byte: got %h expected %h", d, rd_ref(22'h20)); end
      hold = 0;
      repeat (50) begin
         tick();
         if (rd_valid !== 1'b1 || rd_data !== d || cmd_q.size() != 1) hold++;
      end
      checks++;
      if (hold != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles expected 0", hold); end
      rd_ready = 1'b1;
      wait_idle(ok);
      checks++;
      if (!ok || rd_q.size() != 2 || rd_q[0] !== rd_ref(22'h20) || rd_q[1] !== rd_ref(22'h21)) begin
         errors++; $display("FAIL bp_stream: got n=%0d %h %h expected 2 %h %h", rd_q.size(), rd_q[0], rd_q[1], rd_ref(22'h20), rd_ref(22'h21));
      end
   endtask

   task automatic test_timeout();
      bit ok, found;
      int n;
      cmd_q.delete();
      rd_q.delete();
      hang = 1;
      op = 2'd3; addr = 22'h05; len = 16'($urandom); go = 1'b1;
      tick();
      go = 1'b0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         found = fl_start;
      end
      n = 0;
      while (err !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (!found || n != 100) begin errors++; $display("FAIL timeout_cycles: got start=%b cycles=%0d expected 1 100", found, n); end
      checks++;
      if (done !== 1'b1 || fl_start !== 1'b0) begin
         errors++; $display("FAIL timeout_finish: got done=%b start=%b expected 1 0", done, fl_start);
      end
      checks++;
      if (cmd_q.size() != 1 || {cmd_q[0].c, cmd_q[0].a} !== {3'd3, 22'h05}) begin
         errors++; $display("FAIL timeout_cmd: got n=%0d %h expected 1 %h", cmd_q.size(), {cmd_q[0].c, cmd_q[0].a}, {3'd3, 22'h05});
      end
      tick();
      checks++;
      if (busy !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got busy=%b err=%b expected 0 1", busy, err); end
      hang = 0;
      repeat (12) tick();
      op = 2'd0; addr = 22'h100; len = 16'd1; go = 1'b1;
      tick();
      go = 1'b0;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", err); end
      wait_idle(ok);
      checks++;
      if (!ok || rd_q.size() != 1 || rd_q[0] !== rd_ref(22'h100)) begin
         errors++; $display("FAIL timeout_recover: got n=%0d %h expected 1 %h", rd_q.size(), rd_q[0], rd_ref(22'h100));
      end
   endtask

   task automatic test_reset_mid();
      bit ok, found;
      cmd_q.delete();
      hang = 1;
      op = 2'd0; addr = 22'h40; len = 16'd3; go = 1'b1;
      tick();
      go = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         found = busy && !fl_start && cmd_q.size() == 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rst_mid_reach: got no WAIT_DONE expected WAIT_DONE"); end
      rst = 1'b1;
      tick();
      checks++;
      if ({busy, done, err, wr_ready, rd_valid, fl_start, fl_cmd, fl_addr, fl_data, rd_data} !== 47'b0) begin
         errors++; $display("FAIL rst_mid_outputs: got %h expected 0", {busy, done, err, wr_ready, rd_valid, fl_start, fl_cmd, fl_addr, fl_data, rd_data});
      end
      rst = 1'b0;
      hang = 0;
      repeat (12) tick();
      do_op(2'd0, 22'h55, 16'd2, 1, ok);
      checks++;
      if (!ok || rd_q.size() != 2 || rd_q[0] !== rd_ref(22'h55) || rd_q[1] !== rd_ref(22'h56)) begin
         errors++; $display("FAIL rst_mid_recover: got n=%0d %h %h expected 2 %h %h", rd_q.size(), rd_q[0], rd_q[1], rd_ref(22'h55), rd_ref(22'h56));
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [1:0] o;
      logic [21:0] a, ea;
      logic [15:0] l;
      logic [2:0] ec;
      int ne;
      for (int n = 0; n < 25; n++) begin
         o = 2'($urandom);
         a = $urandom_range(0, 3) == 0 ? 22'(22'h3FFFFF - $urandom_range(0, 3)) : 22'($urandom);
         l = 16'($urandom_range(0, 5));
         wbytes.delete();
         for (int i = 0; i < l; i++) wbytes.push_back(8'($urandom));
         do_op(o, a, l, $urandom_range(0, 3), ok);
         ne = o[1] ? 1 : int'(l);
         ec = o == 2'd0 ? 3'd0 : o == 2'd1 ? 3'd1 : o == 2'd2 ? 3'd4 : 3'd3;
         checks++;
         if (!ok || done_cnt != 1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rand%0d_done: got ok=%b done=%0d busy=%b err=%b expected 1 1 0 0", n, ok, done_cnt, busy, err);
         end
         checks++;
         if (cmd_q.size() != ne) begin errors++; $display("FAIL rand%0d_cmd_count: got %0d expected %0d", n, cmd_q.size(), ne); end
         for (int i = 0; i < ne && i < cmd_q.size(); i++) begin
            ea = o == 2'd2 ? 22'h0 : o == 2'd3 ? a : 22'(a + i);
            checks++;
            if ({cmd_q[i].c, cmd_q[i].a} !== {ec, ea} || (o == 2'd1 && cmd_q[i].d !== wbytes[i])) begin
               errors++; $display("FAIL rand%0d_cmd[%0d]: got %h expected %h/%h", n, i, cmd_q[i], {ec, ea}, o == 2'd1 ? wbytes[i] : 8'h0);
            end
         end
         if (o == 2'd0) begin
            checks++;
            if (rd_q.size() != l) begin errors++; $display("FAIL rand%0d_rd_count: got %0d expected %0d", n, rd_q.size(), l); end
            for (int i = 0; i < l && i < rd_q.size(); i++) begin
               checks++;
               if (rd_q[i] !== rd_ref(22'(a + i))) begin
                  errors++; $display("FAIL rand%0d_rd[%0d]: got %h expected %h", n, i, rd_q[i], rd_ref(22'(a + i)));
               end
            end
         end
         checks++;
         if (getwr_start != 0) begin errors++; $display("FAIL rand%0d_start_in_getwr: got %0d expected 0", n, getwr_start); end
      end
   endtask

   task automatic test_stability();
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL cmd_stability: got %0d changes expected 0", stab_err); end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_program();
      test_latency();
      test_zero_len();
      test_erase();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_random();
      test_stability();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
